// File: rtl/median_pkg.sv
// Shared definitions for the median filter scheduler and datapath.
package median_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

endpackage

// File: rtl/median_scan_scheduler_raster_counter.sv
// Raster-order row/column counter with a mod-3 row select and a past-the-end flag.
module raster_counter
    import median_pkg::*;
#(
    parameter int unsigned WIDTH  = 430,
    parameter int unsigned HEIGHT = 554,
    parameter int unsigned CW     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [CW-1:0]    row,
    output logic [CW-1:0]    col,
    output logic [SEL_W-1:0] sel,
    output logic             finished
);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    row_q, col_q;
    logic [SEL_W-1:0] sel_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_q <= '0;
            col_q <= '0;
            sel_q <= '0;
        end else if (adv) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + CW'(1);
                sel_q <= (sel_q == SEL_W'(2)) ? '0 : sel_q + SEL_W'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign sel      = sel_q;
    assign finished = (row_q == CW'(HEIGHT));

endmodule

// File: rtl/median_scan_scheduler.sv
// Raster-scan scheduler for the 3x3 median filter: throttles pixel intake against the
// 3-line buffer, issues windows to the pipeline and owns its valid bits and handshake.
module median_scan_scheduler
    import median_pkg::*;
#(
    parameter int unsigned WIDTH   = 430,
    parameter int unsigned HEIGHT  = 554,
    parameter int unsigned MED_LAT = 4,
    parameter int unsigned CW      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lb_wr_en,
    output logic [SEL_W-1:0] lb_wr_sel,
    output logic [CW-1:0]    lb_wr_col,
    output logic             iss,
    output logic [CW-1:0]    iss_row,
    output logic [CW-1:0]    iss_col,
    output logic [SEL_W-1:0] iss_sel_mid,
    output logic             iss_border,
    output logic             pipe_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);
    localparam int unsigned   CW1    = CW + 1;
    localparam logic [CW:0]   H_LAST = CW1'(HEIGHT - 1);
    localparam logic [CW-1:0] R_LAST = CW'(HEIGHT - 1);
    localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [MED_LAT-1:0] vsr_q;
    logic               frame_start, run, avail;
    logic               in_fin, iss_fin;
    logic [CW-1:0]      in_row, in_col, out_row, out_col, nc;
    logic [CW:0]        iss_row_p1, nr;
    logic [SEL_W-1:0]   unused_out_sel;
    logic               unused_out_fin;

    assign run         = (state_q == ST_RUN);
    assign frame_start = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // Input may run at most one row ahead of the cursor so row iss_row-1 stays intact.
    assign iss_row_p1 = {1'b0, iss_row} + CW1'(1);
    assign in_ready   = run && !in_fin && ({1'b0, in_row} <= iss_row_p1);
    assign lb_wr_en   = in_valid && in_ready;
    assign lb_wr_col  = in_col;

    // The window is complete once the pixel below-right of the centre (clamped) is stored.
    assign nr    = (iss_row_p1 > H_LAST) ? H_LAST : iss_row_p1;
    assign nc    = (iss_col == W_LAST) ? W_LAST : iss_col + CW'(1);
    assign avail = ({1'b0, in_row} > nr) || ({1'b0, in_row} == nr && in_col > nc);

    assign out_valid  = vsr_q[MED_LAT-1];
    assign pipe_en    = !out_valid || out_ready;
    assign iss        = run && !iss_fin && avail && pipe_en;
    assign iss_border = (iss_row == '0) || (iss_row == R_LAST) ||
                        (iss_col == '0) || (iss_col == W_LAST);
    assign out_last   = out_valid && (out_row == R_LAST) && (out_col == W_LAST);

    assign busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done  = (state_q == ST_DONE);
    assign state = state_q;

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW)) u_in_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_start),
        .adv      (lb_wr_en),
        .row      (in_row),
        .col      (in_col),
        .sel      (lb_wr_sel),
        .finished (in_fin)
    );

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW)) u_iss_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_start),
        .adv      (iss),
        .row      (iss_row),
        .col      (iss_col),
        .sel      (iss_sel_mid),
        .finished (iss_fin)
    );

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW)) u_out_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_start),
        .adv      (out_valid && out_ready),
        .row      (out_row),
        .col      (out_col),
        .sel      (unused_out_sel),
        .finished (unused_out_fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vsr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                vsr_q <= '0;
            end else if (pipe_en) begin
                vsr_q <= MED_LAT'({vsr_q, iss});
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN:   if (iss && iss_row == R_LAST && iss_col == W_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (vsr_q == '0) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_median_scan_scheduler.sv
// Self-checking bench for median_scan_scheduler on a 4x3 frame with a 2-stage pipeline.
module tb_median_scan_scheduler;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int L  = 2;
    localparam int CW = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic          in_ready, lb_wr_en, iss, iss_border, pipe_en, out_valid, out_last;
    logic          busy, done;
    logic [1:0]    lb_wr_sel, iss_sel_mid;
    logic [CW-1:0] lb_wr_col, iss_row, iss_col;
    logic [2:0]    state;

    median_scan_scheduler #(.WIDTH(W), .HEIGHT(H), .MED_LAT(L), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lb_wr_en    (lb_wr_en),
        .lb_wr_sel   (lb_wr_sel),
        .lb_wr_col   (lb_wr_col),
        .iss         (iss),
        .iss_row     (iss_row),
        .iss_col     (iss_col),
        .iss_sel_mid (iss_sel_mid),
        .iss_border  (iss_border),
        .pipe_en     (pipe_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int idx;
        int cyc;
    } ent_t;

    typedef struct {
        bit gaps;
        int stall;
        int mid_start;
        int exp_first;
        int exp_out;
    } frame_t;

    ent_t sb[$];
    bit   mon_en = 1'b0;
    bit   lat_chk, prev_stall;
    int   cyc = 0;
    int   acc_r, acc_c, acc_n, exp_r, exp_c, iss_n, out_n, first_acc, interior_n;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference monitor: raster-order models of intake, issue and output.
    always @(negedge clk) begin : monitor
        int   nr, nc;
        bit   brd;
        ent_t e;
        if (mon_en) begin
            if (prev_stall) check("hold_out_valid", out_valid, 1);
            prev_stall = out_valid && !out_ready;
            check("pipe_en", pipe_en, int'(!out_valid || out_ready));
            if (out_valid && !out_ready) check("stall_no_iss", iss, 0);
            if (!out_valid) check("out_last_idle", out_last, 0);
            if (iss) begin
                nr  = (exp_r + 1 > H - 1) ? H - 1 : exp_r + 1;
                nc  = (exp_c + 1 > W - 1) ? W - 1 : exp_c + 1;
                brd = (exp_r == 0) || (exp_r == H - 1) || (exp_c == 0) || (exp_c == W - 1);
                if (first_acc < 0) first_acc = acc_n;
                check("iss_row", iss_row, exp_r);
                check("iss_col", iss_col, exp_c);
                check("iss_sel_mid", iss_sel_mid, exp_r % 3);
                check("iss_border", iss_border, brd);
                check("iss_avail", int'(acc_n > nr * W + nc), 1);
                if (!brd) interior_n++;
                sb.push_back('{exp_r * W + exp_c, cyc});
                iss_n++;
                if (exp_c == W - 1) begin
                    exp_c = 0;
                    exp_r++;
                end else begin
                    exp_c++;
                end
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_order", e.idx, out_n);
                    check("out_last", out_last, int'(e.idx == N - 1));
                    if (lat_chk) check("latency", cyc - e.cyc, L);
                end
                out_n++;
            end
            check("lb_wr_en", lb_wr_en, int'(in_valid && in_ready));
            if (lb_wr_en) begin
                check("lb_wr_col", lb_wr_col, acc_c);
                check("lb_wr_sel", lb_wr_sel, acc_r % 3);
                acc_n++;
                if (acc_c == W - 1) begin
                    acc_c = 0;
                    acc_r++;
                end else begin
                    acc_c++;
                end
            end
        end
    end

    task automatic init_model(input bit lat);
        acc_r = 0; acc_c = 0; acc_n = 0; exp_r = 0; exp_c = 0;
        iss_n = 0; out_n = 0; first_acc = -1; interior_n = 0;
        prev_stall = 1'b0;
        lat_chk = lat;
        sb.delete();
    endtask

    task automatic run_frame(input frame_t f);
        bit fin, saw_drain;
        init_model(f.stall == 0);
        mon_en    = 1'b1;
        fin       = 1'b0;
        saw_drain = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = (f.stall == 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("state_run", state, 1);
        check("busy_run", busy, 1);
        check("done_cleared", done, 0);
        for (int k = 0; k < 400 && !fin; k++) begin
            in_valid = f.gaps ? (k % 2 == 0) : 1'b1;
            if (f.stall > 0 && k == f.stall) begin
                check("guard_iss_count", iss_n, 2);
                check("guard_accepts", acc_n, 2 * W);
                check("guard_in_ready", in_ready, 0);
                check("guard_pipe_en", pipe_en, 0);
                check("guard_out_valid", out_valid, 1);
            end
            out_ready = (k >= f.stall);
            start     = (k == f.mid_start);
            @(posedge clk); #1;
            if (k == f.mid_start) check("mid_start_ignored", state, 1);
            start = 1'b0;
            if (state == 3'd2) saw_drain = 1'b1;
            fin = done;
        end
        in_valid = 1'b0;
        check("frame_timeout", fin, 1);
        check("saw_drain", saw_drain, 1);
        check("accepted", acc_n, N);
        check("iss_count", iss_n, N);
        check("out_count", out_n, f.exp_out);
        check("first_iss_accepts", first_acc, f.exp_first);
        check("interior_count", interior_n, 2);
        check("sb_empty", sb.size(), 0);
        check("state_done", state, 3);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done, 1);
        check("busy_done", busy, 0);
        mon_en = 1'b0;
    endtask

    frame_t frames[4];

    initial begin
        frames[0] = '{gaps: 1'b0, stall: 0,  mid_start: -1, exp_first: 6, exp_out: N};
        frames[1] = '{gaps: 1'b1, stall: 0,  mid_start: -1, exp_first: 6, exp_out: N};
        frames[2] = '{gaps: 1'b0, stall: 30, mid_start: -1, exp_first: 6, exp_out: N};
        frames[3] = '{gaps: 1'b0, stall: 0,  mid_start: 10, exp_first: 6, exp_out: N};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_iss", iss, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", state, 0);

        for (int i = 0; i < 4; i++) run_frame(frames[i]);

        // Abort a frame with reset once five pixels have been delivered.
        init_model(1'b1);
        mon_en    = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && out_n < 5; k++) begin
            @(posedge clk); #1;
        end
        check("reached_out5", out_n, 5);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_state", state, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_iss", iss, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_resume", out_valid, 0);

        run_frame(frames[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
